uart_axis_receiver: RTL and testbench
=====================================

Name: uart_axis_receiver

Overview:
- Serial-to-stream receiver; the input-side counterpart of the UART emitter path.
- Samples an asynchronous 8N1 UART line and delivers each received byte on an 8-bit AXI-Stream-style master (tdata/tlast/tvalid/tready), buffered by a small FIFO.
- Sits between a board RX pin and a stream consumer, such as a command parser feeding the core array.

Parameters:
- CLK_FREQ, 16000000, i_clk frequency in Hz
- BAUD_RATE, 57600, serial bit rate
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2
- LAST_CHAR, 8'h0A, received byte value that sets o_tlast

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_uart_rx  in  1  serial line, idle high, asynchronous to i_clk
- o_tdata  out  8  received byte
- o_tlast  out  1  high when o_tdata == LAST_CHAR
- o_tvalid  out  1  FIFO non-empty
- i_tready  in  1  consumer accepts o_tdata this cycle
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: byte dropped, FIFO full

Behaviour:
- DIV = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, integer. DIV >= 4 is required; otherwise elaboration fails.
- i_uart_rx passes through a 2-FF synchroniser that resets to 1. All decisions below use the synchronised value rx_s.
- Reset (i_rst_n = 0, asynchronous):
  - FSM goes to IDLE, FIFO empties, shift register and bit counter clear.
  - All outputs 0.
  - Reset mid-frame aborts the frame; nothing is pushed.
- FSM states IDLE, START, DATA, STOP, WAIT_HIGH. A single down-counter cnt generates sample points.
  - IDLE: when rx_s == 0, load cnt = DIV/2 - 1 and go to START.
  - START: at cnt == 0, sample rx_s.
    - 0: load cnt = DIV - 1, bit index 0, go to DATA.
    - 1: treat as glitch, return to IDLE, no error.
  - DATA: at cnt == 0, shift rx_s in LSB-first and reload DIV - 1. After the 8th bit, go to STOP.
  - STOP: at cnt == 0, sample rx_s.
    - 1: push {byte == LAST_CHAR, byte} into the FIFO, go to IDLE.
    - If the FIFO is full with no pop in the same cycle: drop the byte and pulse o_overrun instead of pushing.
    - 0: pulse o_frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a break from producing 0x00 bytes.
- FIFO:
  - 9 bits wide (tlast + tdata).
  - o_tvalid = !empty. o_tdata and o_tlast show the head entry.
  - Pop when o_tvalid && i_tready.
  - Push and pop in the same cycle are both performed. When full, a simultaneous pop makes room, so no overrun.
  - Occupancy wraps via pointers with an extra MSB for full/empty distinction.
- Handshake: while o_tvalid && !i_tready, o_tdata and o_tlast must hold stable. o_tvalid never drops without a pop.
- Latency: a pushed byte appears on o_tvalid in the cycle after the stop-bit sample cycle.
- Byte order out equals byte order received; no reordering.
- o_frame_err and o_overrun are registered and high for exactly one cycle per event.

Test Plan:
Bench parameters: CLK_FREQ = 1600000, BAUD_RATE = 100000, giving DIV = 16. Each bit is 16 cycles.
1. i_tready = 1; send 0x55 -> exactly one o_tvalid cycle with o_tdata = 0x55, o_tlast = 0, about 154 ± 3 cycles after the start edge; no error pulses.
2. Send 0x0A then 0x41 -> outputs 0x0A with o_tlast = 1, then 0x41 with o_tlast = 0.
3. Pulse i_uart_rx low for 4 cycles, then hold high for 200 cycles -> o_tvalid, o_frame_err and o_overrun all stay 0.
4. Send 0xA3 with the stop bit driven low, hold low 40 cycles, release, then send 0x3C -> o_frame_err pulses once, 0xA3 never appears, 0x3C is received correctly.
5. i_tready = 0; send 0x01 to 0x05 back-to-back -> o_overrun pulses once, at the 5th byte's stop sample. Head stays 0x01 throughout the stall. Raising i_tready then yields 0x01, 0x02, 0x03, 0x04 on consecutive cycles, then o_tvalid = 0.
6. Assert i_rst_n = 0 for 3 cycles mid-way through 0xFF's data bits -> all outputs 0 immediately. After release and a line-high idle, send 0x81 -> only 0x81 is output.

Source files
------------

// File: rtl/uart_axis_receiver.sv
// uart_axis_receiver: 8N1 UART line receiver feeding a small AXI-Stream FIFO.
// A half-bit start check, mid-bit sampling from one down-counter, and a
// WAIT_HIGH state so a held-low line (break) yields a single framing error.
module uart_axis_receiver #(
  parameter int          CLK_FREQ   = 16000000,
  parameter int          BAUD_RATE  = 57600,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  LAST_CHAR  = 8'h0A
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);

  generate
    if (DIV < 4) begin : g_div_chk
      $error("uart_axis_receiver: clock/baud ratio below 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_axis_receiver: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          rx_meta, rx_s;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push_req, push_ok;
  logic [8:0]    head;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && i_tready;
  assign push_req = (state == STOP) && (cnt == '0) && rx_s;
  assign push_ok  = push_req && (!full || pop);
  assign head     = mem[rd_ptr[AW-1:0]];

  assign o_tvalid = !empty;
  assign o_tdata  = o_tvalid ? head[7:0] : 8'h00;
  assign o_tlast  = o_tvalid & head[8];

  // Receive FSM: counter-driven mid-bit sampling, registered error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bidx        <= '0;
      shreg       <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_LD;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!rx_s) begin
            cnt   <= FULL_LD;
            bidx  <= '0;
            state <= DATA;
          end else state <= IDLE;
        end
        DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= FULL_LD;
            bidx  <= bidx + 1'b1;
            if (bidx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rx_s) begin
            o_overrun <= full && !pop;
            state     <= IDLE;
          end else begin
            o_frame_err <= 1'b1;
            state       <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers; the extra MSB tells full from empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are masked by o_tvalid so they need no reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {(shreg == LAST_CHAR), shreg};
  end

endmodule

// File: tb/tb_uart_axis_receiver.sv
// tb_uart_axis_receiver: scoreboard bench for the UART-to-stream receiver.
module tb_uart_axis_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] tdata;
  logic       tlast, tvalid, tready, frame_err, overrun;

  uart_axis_receiver #(
    .CLK_FREQ(1600000), .BAUD_RATE(100000), .FIFO_DEPTH(4), .LAST_CHAR(8'h0A)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx),
    .o_tdata(tdata), .o_tlast(tlast), .o_tvalid(tvalid), .i_tready(tready),
    .o_frame_err(frame_err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc = 0;
  int         pop_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int         last_pop_cyc = 0;
  logic [8:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every handshake, checks stall hold.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (stall_prev) begin
        n_tests++;
        if (!(tvalid === 1'b1 && tdata === prev_data && tlast === prev_last)) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   tvalid, tdata, tlast, prev_data, prev_last);
        end
      end
      if (tvalid && tready) begin
        pop_cnt++;
        last_pop_cyc = cyc;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got data=%h last=%b, required no output", tdata, tlast);
        end else begin
          e = exp_q.pop_front();
          if ({tlast, tdata} !== e) begin
            n_fail++;
            $display("FAIL byte_order: got last=%b data=%h, required last=%b data=%h",
                     tlast, tdata, e[8], e[7:0]);
          end
        end
      end
      stall_prev = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end else stall_prev = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic expect_out);
    if (expect_out) exp_q.push_back({(b == 8'h0A), b});
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = stop;
    tick(16);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick(1);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still expected after %0d cycles, required 0",
               name, exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({tdata, tlast, tvalid, frame_err, overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h last=%b valid=%b fe=%b ov=%b, required all 0",
               tdata, tlast, tvalid, frame_err, overrun);
    end
  endtask

  task automatic test_single();
    int p0, f0, o0, t0, lat;
    p0 = pop_cnt; f0 = fe_cnt; o0 = ov_cnt;
    t0 = cyc;
    send_byte(8'h55, 1'b1, 1'b1);
    tick(40);
    lat = last_pop_cyc - t0;
    n_tests++;
    if (pop_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d valid cycles, required 1", pop_cnt - p0);
    end
    n_tests++;
    if (lat < 151 || lat > 157) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles, required 151..157", lat);
    end
    n_tests++;
    if (fe_cnt != f0 || ov_cnt != o0) begin
      n_fail++;
      $display("FAIL single_errors: got fe=%0d ov=%0d pulses, required 0 0", fe_cnt - f0, ov_cnt - o0);
    end
    wait_drain("single", 10);
  endtask

  task automatic test_tlast();
    send_byte(8'h0A, 1'b1, 1'b1);
    send_byte(8'h41, 1'b1, 1'b1);
    wait_drain("tlast", 200);
  endtask

  task automatic test_glitch();
    int p0, f0, o0;
    p0 = pop_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(200);
    n_tests++;
    if (pop_cnt != p0) begin
      n_fail++;
      $display("FAIL glitch_valid: got %0d bytes, required 0", pop_cnt - p0);
    end
    n_tests++;
    if (fe_cnt != f0) begin
      n_fail++;
      $display("FAIL glitch_frame_err: got %0d pulses, required 0", fe_cnt - f0);
    end
    n_tests++;
    if (ov_cnt != o0) begin
      n_fail++;
      $display("FAIL glitch_overrun: got %0d pulses, required 0", ov_cnt - o0);
    end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = fe_cnt;
    send_byte(8'hA3, 1'b0, 1'b0);
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(20);
    n_tests++;
    if (fe_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL frame_err_pulse: got %0d pulses, required 1", fe_cnt - f0);
    end
    send_byte(8'h3C, 1'b1, 1'b1);
    wait_drain("frame_err", 200);
  endtask

  task automatic test_back_to_back();
    int o0, p0;
    tready = 1'b0;
    o0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b1);
    n_tests++;
    if (ov_cnt != o0) begin
      n_fail++;
      $display("FAIL overrun_early: got %0d pulses before 5th byte, required 0", ov_cnt - o0);
    end
    send_byte(8'h05, 1'b1, 1'b0);
    tick(5);
    n_tests++;
    if (ov_cnt - o0 != 1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %0d pulses, required 1", ov_cnt - o0);
    end
    n_tests++;
    if (tvalid !== 1'b1 || tdata !== 8'h01) begin
      n_fail++;
      $display("FAIL stall_head: got valid=%b data=%h, required valid=1 data=01", tvalid, tdata);
    end
    p0 = pop_cnt;
    tready = 1'b1;
    tick(4);
    n_tests++;
    if (pop_cnt - p0 != 4) begin
      n_fail++;
      $display("FAIL drain_consecutive: got %0d pops in 4 cycles, required 4", pop_cnt - p0);
    end
    n_tests++;
    if (tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: got valid=%b, required 0", tvalid);
    end
    wait_drain("back_to_back", 5);
  endtask

  task automatic test_reset_midframe();
    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(40);
    rst_n = 1'b0;
    #1;
    test_reset();
    tick(3);
    rst_n = 1'b1;
    tick(40);
    send_byte(8'h81, 1'b1, 1'b1);
    wait_drain("reset_midframe", 200);
  endtask

  initial begin
    rst_n  = 1'b0;
    rx     = 1'b1;
    tready = 1'b1;
    tick(3);
    test_reset();
    rst_n = 1'b1;
    tick(20);
    test_single();
    test_tlast();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    tick(20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
